// File: rtl/eth_tx_framer.sv
// Ethernet TX framing stage: preamble/SFD, pulled frame bytes, zero pad,
// CRC-32 FCS and interframe gap, on a byte stream toward the dibit serializer.
module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_LEN      = 60,
  parameter int IFG_CYCLES   = 48,
  parameter int CNT_LEN      = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       downstream_rdy,
  output logic       upstream_readclk,
  input  logic       inclk,
  input  logic [7:0] in,
  input  logic       in_done,
  output logic       outclk,
  output logic [7:0] out,
  output logic       done,
  output logic       busy
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_IFG  = 3'd6;

  localparam int AW = 16;
  localparam logic [AW-1:0]      PRE_LAST = AW'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
  localparam logic [AW-1:0]      IFG_LAST = AW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [CNT_LEN:0]   MIN_W    = (CNT_LEN+1)'(MIN_LEN);
  localparam logic [CNT_LEN-1:0] CNT_MAX  = '1;

  logic [2:0]         state_q, state_d;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic [AW-1:0]      aux_q, aux_d;
  logic [31:0]        crc_q, crc_d;
  logic               waiting_q, waiting_d;
  logic [CNT_LEN:0]   cnt_inc;
  logic [CNT_LEN-1:0] cnt_sat;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Unsaturated count+1 drives the pad decision; the stored count saturates.
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    aux_d            = aux_q;
    crc_d            = crc_q;
    waiting_d        = waiting_q;
    outclk           = 1'b0;
    out              = 8'h00;
    done             = 1'b0;
    upstream_readclk = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = (PREAMBLE_LEN > 0) ? S_PRE : S_SFD;
        cnt_d     = '0;
        aux_d     = '0;
        crc_d     = '1;
        waiting_d = 1'b0;
      end
      S_PRE: begin
        outclk = downstream_rdy;
        out    = 8'h55;
        if (downstream_rdy) begin
          if (aux_q == PRE_LAST) begin
            state_d = S_SFD;
            aux_d   = '0;
          end else aux_d = aux_q + 1'b1;
        end
      end
      S_SFD: begin
        outclk = downstream_rdy;
        out    = 8'hD5;
        if (downstream_rdy) state_d = S_DATA;
      end
      S_DATA: begin
        upstream_readclk = downstream_rdy && !waiting_q;
        if (upstream_readclk) waiting_d = 1'b1;
        // Deliveries without an outstanding request are dropped.
        if (inclk && waiting_q) begin
          waiting_d = 1'b0;
          outclk    = 1'b1;
          out       = in;
          cnt_d     = cnt_sat;
          crc_d     = crc_byte(crc_q, in);
          if (in_done) state_d = (cnt_inc < MIN_W) ? S_PAD : S_FCS;
        end
      end
      S_PAD: begin
        outclk = downstream_rdy;
        if (downstream_rdy) begin
          cnt_d = cnt_sat;
          crc_d = crc_byte(crc_q, 8'h00);
          if (cnt_inc >= MIN_W) state_d = S_FCS;
        end
      end
      S_FCS: begin
        outclk = downstream_rdy;
        out    = ~crc_q[{aux_q[1:0], 3'b000} +: 8];
        if (downstream_rdy) begin
          if (aux_q[1:0] == 2'd3) begin
            done    = 1'b1;
            aux_d   = '0;
            state_d = (IFG_CYCLES > 0) ? S_IFG : S_IDLE;
          end else aux_d = aux_q + 1'b1;
        end
      end
      S_IFG: begin
        if (aux_q == IFG_LAST) begin
          state_d = S_IDLE;
          aux_d   = '0;
        end else aux_d = aux_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      aux_q     <= '0;
      crc_q     <= 32'hFFFFFFFF;
      waiting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aux_q     <= aux_d;
      crc_q     <= crc_d;
      waiting_q <= waiting_d;
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: frame-level vector table (one MIN_LEN=0 instance,
// one default instance) plus hand sequences for reset and stray deliveries.
module tb_eth_tx_framer;
  localparam int IFG = 48;

  logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0, rdy = 1'b0;
  logic inclk = 1'b0, in_done = 1'b0;
  logic [7:0] in_b = 8'h00;
  logic rq0, rq1, oc0, oc1, dn0, dn1, bz0, bz1;
  logic [7:0] ob0, ob1;

  always #5 clk = ~clk;

  eth_tx_framer #(.MIN_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .downstream_rdy(rdy),
    .upstream_readclk(rq0), .inclk(inclk), .in(in_b), .in_done(in_done),
    .outclk(oc0), .out(ob0), .done(dn0), .busy(bz0));

  eth_tx_framer dut1 (
    .clk(clk), .rst(rst), .start(start1), .downstream_rdy(rdy),
    .upstream_readclk(rq1), .inclk(inclk), .in(in_b), .in_done(in_done),
    .outclk(oc1), .out(ob1), .done(dn1), .busy(bz1));

  typedef struct {
    int          sel;       // 0: MIN_LEN=0 instance, 1: default instance
    int          len;       // delivered frame bytes
    int          pat;       // payload pattern
    int          lat;       // upstream delivery latency in cycles
    bit          slow;      // rdy high one cycle in four (held while a request is open)
    int          abort_at;  // reset after this many delivered bytes, 0 = none
    bit          stray;     // pulse start during PAD and IFG
    int          exp_len;   // bytes on wire
    logic [31:0] exp_fcs;   // FCS as {b3,b2,b1,b0}, 0 = not checked
  } vec_t;

  vec_t tbl[8];
  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] pbyte(input int pat, input int i);
    case (pat)
      0:       return 8'(8'h31 + i);
      1:       return (i == 0) ? 8'hFF : 8'h00;
      default: return 8'((i * 7 + 3) & 255);
    endcase
  endfunction

  task automatic pulse_start(input int sel);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
  endtask

  task automatic run_frame(input int vi, input vec_t v);
    logic [7:0] got[$];
    logic [7:0] exp[$];
    logic [7:0] b, ob;
    logic [31:0] c;
    logic rq, oc, dn, bz;
    int pend = 0, idx = 0, last_out = -1, done_cnt = 0, done_pos = -1, end_cyc = -1;
    int win = 0, minl, mism, plen;
    bit outst = 0, aborted = 0, ended = 0, r_hold, prev_rdy = 0, timeout = 1;
    bit bad_rq = 0, bad_win = 0, bad_oc = 0, abort_ok = 0, s_pad = 0, idle_bad = 0;

    minl = (v.sel == 0) ? 0 : 60;
    plen = (v.len > minl) ? v.len : minl;
    for (int i = 0; i < 7; i++) exp.push_back(8'h55);
    exp.push_back(8'hD5);
    c = '1;
    for (int i = 0; i < plen; i++) begin
      b = (i < v.len) ? pbyte(v.pat, i) : 8'h00;
      exp.push_back(b);
      c = crc8(c, b);
    end
    for (int k = 0; k < 4; k++) exp.push_back(~c[8*k +: 8]);

    @(posedge clk); #1;
    rdy = 1'b1;
    pulse_start(v.sel);
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0; rst = 1'b0;
      inclk = 1'b0; in_done = 1'b0; in_b = 8'h00;
      r_hold = outst;
      if (outst && !aborted) begin
        pend--;
        if (pend == 0) begin
          inclk   = 1'b1;
          in_b    = pbyte(v.pat, idx);
          in_done = (idx == v.len - 1);
          idx++;
          outst   = 0;
        end
      end
      rdy = v.slow ? ((cyc % 4 == 0) || r_hold) : 1'b1;
      if (v.abort_at > 0 && !aborted && idx == v.abort_at && !inclk) begin
        rst = 1'b1;
        aborted = 1;
      end
      if (v.stray && !s_pad && got.size() == 8 + v.len + 3) begin
        pulse_start(v.sel);
        s_pad = 1;
      end
      if (v.stray && last_out >= 0 && got.size() == v.exp_len &&
          (cyc == last_out + 10 || cyc == last_out + IFG))
        pulse_start(v.sel);

      @(negedge clk);
      rq = v.sel ? rq1 : rq0;
      oc = v.sel ? oc1 : oc0;
      ob = v.sel ? ob1 : ob0;
      dn = v.sel ? dn1 : dn0;
      bz = v.sel ? bz1 : bz0;
      if (aborted) begin
        if (!rst) begin
          abort_ok = !bz && !oc && !rq;
          ended = 1;
          timeout = 0;
        end
      end else begin
        if (rq) begin
          if (outst) bad_rq = 1;
          outst = 1;
          pend  = v.lat;
        end
        if (oc) begin
          got.push_back(ob);
          last_out = cyc;
          if (!rdy) bad_oc = 1;
          if (dn) begin
            done_cnt++;
            done_pos = got.size();
          end
        end
        if (rdy && !prev_rdy) win = 0;
        if (oc) win++;
        if (v.slow && win > 1) bad_win = 1;
        prev_rdy = rdy;
        if (got.size() > 0 && !bz) begin
          ended = 1;
          timeout = 0;
          end_cyc = cyc;
        end
      end
    end
    start0 = 1'b0; start1 = 1'b0; rst = 1'b0; inclk = 1'b0; in_done = 1'b0;

    check($sformatf("v%0d_timeout", vi), timeout, 0);
    mism = -1;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i] && mism < 0) mism = i;
    check($sformatf("v%0d_len", vi), got.size(), v.exp_len);
    check($sformatf("v%0d_first_bad_byte", vi), mism, -1);
    if (v.abort_at > 0) begin
      check($sformatf("v%0d_abort_idle", vi), abort_ok, 1);
      check($sformatf("v%0d_abort_done", vi), done_cnt, 0);
    end else begin
      check($sformatf("v%0d_done_cnt", vi), done_cnt, 1);
      check($sformatf("v%0d_done_pos", vi), done_pos, v.exp_len);
      check($sformatf("v%0d_ifg", vi), end_cyc - last_out, IFG + 1);
      c = '1;
      for (int i = 8; i < got.size(); i++) c = crc8(c, got[i]);
      check($sformatf("v%0d_residue", vi), c, 32'hDEBB20E3);
      if (v.exp_fcs != 32'h0 && got.size() >= 4)
        check($sformatf("v%0d_fcs", vi),
              {got[got.size()-1], got[got.size()-2], got[got.size()-3], got[got.size()-4]},
              v.exp_fcs);
      check($sformatf("v%0d_rq_while_waiting", vi), bad_rq, 0);
      check($sformatf("v%0d_outclk_no_rdy", vi), bad_oc, 0);
      if (v.slow) check($sformatf("v%0d_one_per_window", vi), bad_win, 0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bz0 || bz1) idle_bad = 1;
    end
    check($sformatf("v%0d_stays_idle", vi), idle_bad, 0);
  endtask

  initial begin
    tbl[0] = '{0,  9, 0, 2, 1'b0,  0, 1'b0, 21, 32'hCBF43926};
    tbl[1] = '{1, 14, 1, 2, 1'b0,  0, 1'b0, 72, 32'h0};
    tbl[2] = '{1, 60, 2, 1, 1'b0,  0, 1'b0, 72, 32'h0};
    tbl[3] = '{1, 64, 2, 3, 1'b0,  0, 1'b0, 76, 32'h0};
    tbl[4] = '{1, 20, 2, 2, 1'b1,  0, 1'b0, 72, 32'h0};
    tbl[5] = '{1, 30, 2, 2, 1'b0, 20, 1'b0, 28, 32'h0};
    tbl[6] = '{1, 14, 1, 1, 1'b0,  0, 1'b1, 72, 32'h0};
    tbl[7] = '{0,  5, 2, 1, 1'b1,  0, 1'b0, 17, 32'h0};

    // Reset values with rdy high.
    rst = 1'b1; rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dut0_outs", {oc0, rq0, dn0, bz0}, 4'b0000);
    check("rst_dut1_outs", {oc1, rq1, dn1, bz1}, 4'b0000);

    // Delivery with no request open, in IDLE, must produce nothing.
    @(posedge clk); #1;
    rst = 1'b0; inclk = 1'b1; in_b = 8'hAA; in_done = 1'b1;
    @(negedge clk);
    check("idle_inclk_outclk", {oc0, oc1}, 2'b00);
    check("idle_inclk_rq", {rq0, rq1}, 2'b00);
    @(posedge clk); #1;
    inclk = 1'b0; in_done = 1'b0;
    @(negedge clk);
    check("idle_inclk_busy", {bz0, bz1}, 2'b00);

    for (int i = 0; i < 8; i++) run_frame(i, tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
